// File: rtl/power_alu.sv
`default_nettype none
// ============================================================================
// Module      : power_alu
// Description : Single-cycle registered signed ALU with an internal
//               accumulator. Each clock applies one of 16 opcodes to operand
//               a and the accumulator b, writes the result back into b, and
//               registers zero/neg/ovf status flags alongside it.
//               Optional macro POWER_ALU_SAT_EN: INC/ADD/SUB/DEC saturate
//               instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module power_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam logic [3:0] c_op_transfer = 4'b0000;
  localparam logic [3:0] c_op_inc      = 4'b0001;
  localparam logic [3:0] c_op_add      = 4'b0010;
  localparam logic [3:0] c_op_sub      = 4'b0011;
  localparam logic [3:0] c_op_dec      = 4'b0100;
  localparam logic [3:0] c_op_ones     = 4'b0101;
  localparam logic [3:0] c_op_and      = 4'b0110;
  localparam logic [3:0] c_op_nand     = 4'b0111;
  localparam logic [3:0] c_op_or       = 4'b1000;
  localparam logic [3:0] c_op_nor      = 4'b1001;
  localparam logic [3:0] c_op_xor      = 4'b1010;
  localparam logic [3:0] c_op_xnor     = 4'b1011;
  localparam logic [3:0] c_op_gt       = 4'b1100;
  localparam logic [3:0] c_op_lt       = 4'b1101;
  localparam logic [3:0] c_op_eq       = 4'b1110;
  localparam logic [3:0] c_op_lnot     = 4'b1111;

  localparam logic [WIDTH:0]   c_one_ext = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_zero    = '0;
  localparam logic [WIDTH-1:0] c_pad     = '0;

  logic [WIDTH-1:0] r_b;
  logic             r_zero;
  logic             r_neg;
  logic             r_ovf;

  // Sign-extended operands: one extra bit holds any true INC/ADD/SUB/DEC result.
  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_sum;
  logic             w_arith;
  logic             w_ovf;
  logic [WIDTH-1:0] w_arith_res;
  logic [WIDTH-1:0] w_res;
  logic             w_gt;
  logic             w_lt;

  assign w_a_ext = {a[WIDTH-1], a};
  assign w_b_ext = {r_b[WIDTH-1], r_b};
  assign w_gt    = $signed(a) > $signed(r_b);
  assign w_lt    = $signed(a) < $signed(r_b);

  // Select the extended-precision arithmetic result for the current opcode.
  always_comb begin
    w_sum   = '0;
    w_arith = 1'b0;
    case (opcode)
      c_op_inc: begin w_sum = w_a_ext + c_one_ext; w_arith = 1'b1; end
      c_op_add: begin w_sum = w_a_ext + w_b_ext;   w_arith = 1'b1; end
      c_op_sub: begin w_sum = w_a_ext - w_b_ext;   w_arith = 1'b1; end
      c_op_dec: begin w_sum = w_a_ext - c_one_ext; w_arith = 1'b1; end
      default:  begin w_sum = '0;                  w_arith = 1'b0; end
    endcase
  end

  // Top two bits of the extended sum disagree exactly when the result does not fit.
  assign w_ovf = w_arith & (w_sum[WIDTH] ^ w_sum[WIDTH-1]);

`ifdef POWER_ALU_SAT_EN
  // Clamp toward the side the true result went: sign bit of the extended sum.
  always_comb begin
    w_arith_res = w_sum[WIDTH-1:0];
    if (w_ovf) begin
      w_arith_res = w_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  // Wrap-around: simply drop the extension bit.
  always_comb begin
    w_arith_res = w_sum[WIDTH-1:0];
  end
`endif

  // Full opcode decode into the next accumulator value.
  always_comb begin
    w_res = a;
    case (opcode)
      c_op_transfer: w_res = a;
      c_op_inc,
      c_op_add,
      c_op_sub,
      c_op_dec:      w_res = w_arith_res;
      c_op_ones:     w_res = ~a;
      c_op_and:      w_res = a & r_b;
      c_op_nand:     w_res = ~(a & r_b);
      c_op_or:       w_res = a | r_b;
      c_op_nor:      w_res = ~(a | r_b);
      c_op_xor:      w_res = a ^ r_b;
      c_op_xnor:     w_res = ~(a ^ r_b);
      c_op_gt:       w_res = {c_pad[WIDTH-2:0], w_gt};
      c_op_lt:       w_res = {c_pad[WIDTH-2:0], w_lt};
      c_op_eq:       w_res = {c_pad[WIDTH-2:0], (a == r_b)};
      c_op_lnot:     w_res = {c_pad[WIDTH-2:0], (a == c_zero)};
      default:       w_res = a;
    endcase
  end

  // Accumulator and flags update together; reset wins over any opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b    <= '0;
      r_zero <= 1'b1;
      r_neg  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_b    <= w_res;
      r_zero <= (w_res == c_zero);
      r_neg  <= w_res[WIDTH-1];
      r_ovf  <= w_ovf;
    end
  end

  assign b    = r_b;
  assign zero = r_zero;
  assign neg  = r_neg;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_power_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_power_alu
// Description : Self-checking bench for power_alu. An independent integer
//               model predicts each result; predictions are queued when the
//               stimulus is driven and compared when the result registers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_power_alu;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             zero;
  logic             neg;
  logic             ovf;

  typedef struct packed {
    logic [WIDTH-1:0] b;
    logic             z;
    logic             n;
    logic             o;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] m_b;
  int               checks;
  int               errors;

  power_alu #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .zero   (zero),
    .neg    (neg),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model built on plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv);
    exp_t e;
    int   sa;
    int   sbv;
    int   r;
    logic arith;
    sa    = int'($signed(av));
    sbv   = int'($signed(bv));
    arith = 1'b0;
    r     = 0;
    e.o   = 1'b0;
    case (op)
      4'd0:  r = sa;
      4'd1:  begin r = sa + 1;   arith = 1'b1; end
      4'd2:  begin r = sa + sbv; arith = 1'b1; end
      4'd3:  begin r = sa - sbv; arith = 1'b1; end
      4'd4:  begin r = sa - 1;   arith = 1'b1; end
      4'd5:  r = int'(~av);
      4'd6:  r = int'(av & bv);
      4'd7:  r = int'(~(av & bv));
      4'd8:  r = int'(av | bv);
      4'd9:  r = int'(~(av | bv));
      4'd10: r = int'(av ^ bv);
      4'd11: r = int'(~(av ^ bv));
      4'd12: r = (sa > sbv) ? 1 : 0;
      4'd13: r = (sa < sbv) ? 1 : 0;
      4'd14: r = (av == bv) ? 1 : 0;
      default: r = (av == 0) ? 1 : 0;
    endcase
    if (arith && (r > 127 || r < -128)) begin
      e.o = 1'b1;
`ifdef POWER_ALU_SAT_EN
      r = (r > 127) ? 127 : -128;
`endif
    end
    e.b = r[WIDTH-1:0];
    e.z = (e.b == '0);
    e.n = e.b[WIDTH-1];
    return e;
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".b"},    b,                         e.b);
      check({tag, ".zero"}, {{(WIDTH-1){1'b0}}, zero}, {{(WIDTH-1){1'b0}}, e.z});
      check({tag, ".neg"},  {{(WIDTH-1){1'b0}}, neg},  {{(WIDTH-1){1'b0}}, e.n});
      check({tag, ".ovf"},  {{(WIDTH-1){1'b0}}, ovf},  {{(WIDTH-1){1'b0}}, e.o});
    end
  endtask

  task automatic apply(input logic [3:0] op, input logic [WIDTH-1:0] av, input string tag);
    exp_t e;
    @(negedge clk);
    rst    = 1'b0;
    opcode = op;
    a      = av;
    e      = model(op, av, m_b);
    m_b    = e.b;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
  endtask

  task automatic do_reset(input logic [3:0] op, input logic [WIDTH-1:0] av, input string tag);
    @(negedge clk);
    rst    = 1'b1;
    opcode = op;
    a      = av;
    #1;
    check({tag, ".hold"}, b, m_b);
    m_b = '0;
    sb_q.push_back('{b: '0, z: 1'b1, n: 1'b0, o: 1'b0});
    @(posedge clk);
    #1;
    compare_out(tag);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    opcode = 4'd0;
    a      = '0;
    m_b    = '0;
    @(posedge clk);
    #1;
    sb_q.push_back('{b: '0, z: 1'b1, n: 1'b0, o: 1'b0});
    compare_out("reset");

    // Transfer
    apply(4'd0, 8'd10,          "xfer10");
    apply(4'd0, 8'd20,          "xfer20");
    apply(4'd0, 8'(-15),        "xferm15");
    // Increment and overflow boundary
    apply(4'd1, 8'(-15),        "inc_m15");
    apply(4'd1, 8'd127,         "inc_127");
    apply(4'd4, 8'h80,          "dec_m128");
    // Accumulate and subtract
    apply(4'd0, 8'(-5),         "load_m5");
    apply(4'd2, 8'd10,          "add10");
    apply(4'd3, 8'd20,          "sub20");
    apply(4'd3, 8'h80,          "sub_m128");
    apply(4'd0, 8'd100,         "load100");
    apply(4'd2, 8'd100,         "add_ovf");
    // Bitwise chain
    apply(4'd0, 8'hFF,          "load_m1");
    apply(4'd6, 8'hFE,          "and_m2");
    apply(4'd6, 8'hFC,          "and_m4");
    apply(4'd6, 8'hF8,          "and_m8");
    apply(4'd10, 8'h0F,         "xor0f");
    apply(4'd9, 8'h00,          "nor00");
    apply(4'd7, 8'h0C,          "nand");
    apply(4'd8, 8'h30,          "or");
    apply(4'd11, 8'h5A,         "xnor");
    // Compares and LNOT
    apply(4'd0, 8'd20,          "load20");
    apply(4'd12, 8'd127,        "gt127");
    apply(4'd13, 8'(-5),        "lt_m5");
    apply(4'd14, 8'd1,          "eq1");
    apply(4'd12, 8'(-3),        "gt_false");
    apply(4'd15, 8'd0,          "lnot0");
    apply(4'd15, 8'd5,          "lnot5");
    apply(4'd5, 8'h80,          "ones_m128");
    // Reset in the middle of an ADD, then resume
    apply(4'd0, 8'd42,          "load42");
    do_reset(4'd2, 8'd3,        "mid_rst");
    apply(4'd2, 8'd7,           "add_after_rst");

    // Random mix against the model
    for (int i = 0; i < 60; i++) begin
      apply(4'($urandom_range(0, 15)), 8'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/power_alu.md
Name: power_alu

Overview:
- Single-cycle, registered 8-bit signed ALU with an internal accumulator.
- Each clock it applies one of 16 opcodes to input operand a and the accumulator b. The result is written back into b, which is also the block's data output.
- Chained operations (load, then combine) run without external feedback wiring.
- Status flags are registered with the result.

Parameters:
- WIDTH, 8, datapath width in bits (signed two's complement); all rules below scale with WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- opcode  input  4  operation select
- a  input  WIDTH  signed operand A
- b  output  WIDTH  signed accumulator / result register (operand B of the next operation)
- zero  output  1  registered: b == 0
- neg  output  1  registered: b[WIDTH-1]
- ovf  output  1  registered: signed overflow of the last arithmetic op

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, b=0, zero=1, neg=0, ovf=0. Reset has priority over opcode.
- Normal operation: every rising edge, b <= f(opcode, a, b). There is no enable and no handshake.
- Latency: result visible 1 cycle after a and opcode are sampled. Inputs are sampled only at the edge.
- B always means the current accumulator value.
- Opcodes (result written to b):
  - 0000 TRANSFER: a
  - 0001 INC: a+1
  - 0010 ADD: a+b
  - 0011 SUB: a−b
  - 0100 DEC: a−1
  - 0101 ONES_COMP: ~a
  - 0110 AND: a&b
  - 0111 NAND: ~(a&b)
  - 1000 OR: a|b
  - 1001 NOR: ~(a|b)
  - 1010 XOR: a^b
  - 1011 XNOR: ~(a^b)
  - 1100 GT: 1 if signed a>b, else 0
  - 1101 LT: 1 if signed a<b, else 0
  - 1110 EQ: 1 if a==b, else 0
  - 1111 LNOT: 1 if a==0, else 0
- Compare and LNOT results are zero-extended to WIDTH.
- Arithmetic (INC, ADD, SUB, DEC): computed in WIDTH+1 bits, truncated to WIDTH (wrap-around).
- ovf=1 when the true signed result lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1]. Examples: 127+1 → −128 with ovf=1; −128−1 → 127 with ovf=1.
- For all non-arithmetic opcodes, ovf is cleared to 0.
- zero and neg are always derived from the new b value and updated in the same edge as b.
- All opcode values are defined; there is no illegal state.
- The block has no state machine; the only state is b plus the flags.

Optional Feature:
- Macro POWER_ALU_SAT_EN.
- Defined: INC, ADD, SUB and DEC saturate instead of wrapping, to +2^(WIDTH−1)−1 (127) or −2^(WIDTH−1) (−128). ovf is still set whenever saturation occurs.
- Not defined: wrap-around behaviour as above.
- Logic and compare opcodes are unaffected either way.

Test Plan:
- Reset, then transfer: rst=1 for 1 edge → b=0, zero=1. Then opcode 0000 with a=10, 20, −15 on successive edges → b=10, 20, −15.
- Increment and overflow: opcode 0001, a=−15 → b=−14; a=127 → b=−128, ovf=1, neg=1. With POWER_ALU_SAT_EN, a=127 → b=127, ovf=1.
- Accumulate and subtract: load a=−5 (0000), then ADD a=10 → b=5; SUB a=20 → b=15; SUB a=−128 with b=15 → b=113, ovf=1.
- Bitwise chain: load a=−1 (b=0xFF), then AND a=−2, −4, −8 → b=0xFE, 0xFC, 0xF8. Then XOR a=0x0F → b=0xF7; NOR a=0x00 → b=0x08.
- Compares and LNOT: b=20, GT a=127 → b=1; then LT a=−5 (b=1) → b=1; then EQ a=1 (b=1) → b=1; LNOT a=0 → 1, a=5 → 0 with zero=1. Also ONES_COMP a=−128 → 127.
- Synchronous reset mid-sequence: assert rst during an ADD cycle → b=0 and flags cleared at that edge. b must not change when rst rises between edges.
